// File: rtl/sigmoid_pkg.sv
// Shared constants, stage-register types and coefficient builder for sigmoid_pwl_pipe.
// The SIG_* constants hold the configuration. Top-level parameters must match them.
package sigmoid_pkg;
  localparam int SIG_DW       = 32;
  localparam int SIG_FW       = 16;
  localparam int SIG_NSEG     = 8;
  localparam int SIG_SAT_LOG2 = 3;
  localparam int SIG_SEG_W    = $clog2(SIG_NSEG);

  localparam logic signed [SIG_DW-1:0]   ONE      = SIG_DW'(longint'(1) << SIG_FW);
  localparam logic signed [2*SIG_DW-1:0] HALF_LSB = (2*SIG_DW)'(longint'(1) << (SIG_FW - 1));

  typedef logic [SIG_NSEG-1:0][SIG_DW-1:0] coef_arr_t;

  typedef struct packed {
    logic                  sign;
    logic                  sat;
    logic [SIG_SEG_W-1:0]  seg;
    logic [SIG_DW-1:0]     ax;
`ifdef SIGMOID_TANH_EN
    logic                  mode;
`endif
  } s1_t;

  typedef struct packed {
    logic                       sign;
    logic                       sat;
    logic signed [2*SIG_DW-1:0] p;
    logic [SIG_DW-1:0]          icpt;
`ifdef SIGMOID_TANH_EN
    logic                       mode;
`endif
  } s2_t;

  // round(ONE * sigmoid(k*W)), W = 2^SAT_LOG2 / NSEG
  function automatic longint endpoint(input int k);
    real w, s;
    w = real'(longint'(1) << SIG_SAT_LOG2) / real'(SIG_NSEG);
    s = 1.0 / (1.0 + $exp(-(real'(k) * w)));
    return longint'($rtoi(s * real'(longint'(1) << SIG_FW) + 0.5));
  endfunction

  // Chord through neighbouring endpoints: slope in Q.FRAC, intercept so the line hits s(k) at kW.
  function automatic coef_arr_t pwl_coefs(input bit want_icpt);
    coef_arr_t c;
    longint    s0, s1, sl, ic;
    c = '0;
    for (int k = 0; k < SIG_NSEG; k++) begin
      s0   = endpoint(k);
      s1   = endpoint(k + 1);
      sl   = ((s1 - s0) * SIG_NSEG) >>> SIG_SAT_LOG2;
      ic   = s0 - (sl * longint'(k) * (longint'(1) << SIG_SAT_LOG2)) / SIG_NSEG;
      c[k] = want_icpt ? SIG_DW'(ic) : SIG_DW'(sl);
    end
    return c;
  endfunction
endpackage

// File: rtl/sigmoid_pwl_pipe_lut.sv
// Combinational segment -> {slope, intercept} table for the positive sigmoid half.
module sigmoid_seg_lut
  import sigmoid_pkg::*;
(
  input  logic [SIG_SEG_W-1:0] seg,
  output logic [SIG_DW-1:0]    slope,
  output logic [SIG_DW-1:0]    icpt
);
  localparam coef_arr_t SLOPES = pwl_coefs(1'b0);
  localparam coef_arr_t ICPTS  = pwl_coefs(1'b1);

  assign slope = SLOPES[seg];
  assign icpt  = ICPTS[seg];
endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// 3-stage piecewise-linear sigmoid with valid/ready stream ports.
// Define SIGMOID_TANH_EN to add the in_mode port and tanh evaluation.
module sigmoid_pwl_pipe
  import sigmoid_pkg::*;
#(
  parameter int DATA_WIDTH   = SIG_DW,
  parameter int FRAC_WIDTH   = SIG_FW,
  parameter int NUM_SEGMENTS = SIG_NSEG,
  parameter int SAT_LOG2     = SIG_SAT_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
`ifdef SIGMOID_TANH_EN
  input  logic                  in_mode,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_y
);
  localparam int DW     = DATA_WIDTH;
  localparam int FW     = FRAC_WIDTH;
  localparam int SEGW   = $clog2(NUM_SEGMENTS);
  localparam int SEG_SH = SAT_LOG2 + FW - SEGW;
  localparam int STAGES = 3;
  localparam logic [DW:0]            SAT_LIM = (DW+1)'(1) << (SAT_LOG2 + FW);
  localparam logic signed [2*DW-1:0] ONE_W   = {{DW{1'b0}}, ONE};

  logic              adv;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_q[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv || !rst_n;

  // Stage 1: magnitude, saturation, segment. Working one bit wider keeps |x| and 2x exact.
  logic signed [DW:0] xe;
  logic [DW:0]        axe;
  always_comb begin
    xe = {in_x[DW-1], in_x};
`ifdef SIGMOID_TANH_EN
    if (in_mode) xe = {in_x, 1'b0};
`endif
    axe       = xe[DW] ? (~xe + 1'b1) : xe;
    s1_d      = '0;
    s1_d.sign = in_x[DW-1];
    s1_d.sat  = (axe >= SAT_LIM);
    s1_d.seg  = SEGW'(axe >> SEG_SH);
    s1_d.ax   = axe[DW-1:0];
`ifdef SIGMOID_TANH_EN
    s1_d.mode = in_mode;
`endif
  end

  // Stage 2: coefficient lookup and product
  logic [DW-1:0] slope, icpt;
  sigmoid_seg_lut u_lut (.seg(s1_q.seg), .slope(slope), .icpt(icpt));

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.sat  = s1_q.sat;
    s2_d.p    = $signed({{DW{slope[DW-1]}}, slope}) * $signed({{DW{1'b0}}, s1_q.ax});
    s2_d.icpt = icpt;
`ifdef SIGMOID_TANH_EN
    s2_d.mode = s1_q.mode;
`endif
  end

  // Stage 3: round, saturate/clamp, mirror for negative inputs
  logic signed [2*DW-1:0] yp;
  logic signed [DW-1:0]   ys, y;
  always_comb begin
    yp = $signed({{DW{s2_q.icpt[DW-1]}}, s2_q.icpt}) + ($signed(s2_q.p + HALF_LSB) >>> FW);
    if (s2_q.sat)         yp = ONE_W;
    else if (yp < 0)      yp = '0;
    else if (yp > ONE_W)  yp = ONE_W;
    ys = yp[DW-1:0];
    y  = s2_q.sign ? (ONE - ys) : ys;
`ifdef SIGMOID_TANH_EN
    if (s2_q.mode) y = (y <<< 1) - ONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      out_y <= '0;
    end else if (adv) begin
      vld_q <= vld_pipe[STAGES-1:0];
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      // out_y only moves for real samples so bubbles never expose garbage
      if (vld_q[STAGES-1]) out_y <= y;
    end
  end
endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Bench for sigmoid_pwl_pipe: vector table, stall/reset sequences, sweep and random streams.
module tb_sigmoid_pwl_pipe;
  localparam int     DW  = 32;
  localparam longint ONE = 65536;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_x = '0, out_y;
  int            n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  sigmoid_pwl_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
`ifdef SIGMOID_TANH_EN
    .in_mode(in_mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  longint ep [0:8] = '{32768, 47911, 57724, 62428, 64357, 65097, 65374, 65476, 65514};

  // Chord interpolation between tabulated sigmoid endpoints, unit-wide segments.
  function automatic longint ref_y(input longint x, input bit mode);
    longint xe, ax, yp, y, f;
    int     k;
    xe = mode ? 2 * x : x;
    ax = (xe < 0) ? -xe : xe;
    if (ax >= 8 * ONE) yp = ONE;
    else begin
      k  = int'(ax / ONE);
      f  = ax - longint'(k) * ONE;
      yp = ep[k] + ((ep[k+1] - ep[k]) * f + ONE / 2) / ONE;
    end
    y = (x < 0) ? ONE - yp : yp;
    if (mode) y = 2 * y - ONE;
    return y;
  endfunction

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct { longint x; longint y; } exp_t;
  exp_t    q[$];
  longint  xin[$];
  bit      mdq[$];
  bit      sweep_chk = 0, have_last = 0, stall_prev = 0;
  longint  last_y = 0, held_y = 0;
  int      n_out = 0;

  function automatic longint sy();
    return longint'($signed(out_y));
  endfunction

  // One clock from a negedge to the next negedge, scoreboarding both ports.
  task automatic cycle();
    exp_t   e;
    bit     acc;
    real    err;
    longint k;
    #1;
    if (rst_n) chk(in_ready == (!out_valid || out_ready), "in_ready_adv", in_ready, !out_valid || out_ready);
    if (stall_prev) chk(out_valid && sy() == held_y, "stall_hold", sy(), held_y);
    stall_prev = out_valid && !out_ready;
    held_y     = sy();
    acc = in_valid && in_ready;
    if (acc) q.push_back('{longint'($signed(in_x)), ref_y(longint'($signed(in_x)), in_mode)});
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk(1'b0, "spurious_out", sy(), 0);
      else begin
        e = q.pop_front();
        chk(sy() == e.y, "stream_y", sy(), e.y);
        n_out++;
        if (sweep_chk) begin
          if (have_last) chk(sy() >= last_y, "monotone", sy(), last_y);
          have_last = 1;
          last_y    = sy();
          err = real'(sy()) - real'(ONE) / (1.0 + $exp(-real'(e.x) / real'(ONE)));
          if (err < 0.0) err = -err;
          chk(err <= 0.02 * real'(ONE), "abs_err", longint'(err), longint'(0.02 * real'(ONE)));
          if (e.x % ONE == 0 && e.x > -8 * ONE && e.x < 8 * ONE) begin
            k = (e.x < 0) ? -e.x / ONE : e.x / ONE;
            chk(sy() == ((e.x < 0) ? ONE - ep[k] : ep[k]), "endpoint", sy(), (e.x < 0) ? ONE - ep[k] : ep[k]);
          end
        end
      end
    end
    @(negedge clk);
    if (acc) begin
      in_valid = 1'b0;
      if (xin.size() > 0) begin void'(xin.pop_front()); void'(mdq.pop_front()); end
    end
  endtask

  // rdy_pat: 0 always ready, 1 toggle, 2 random. gaps: random idle cycles upstream.
  task automatic stream(input int rdy_pat, input bit gaps);
    int cyc = 0;
    int n0  = n_out + xin.size();
    stall_prev = 0;
    while ((xin.size() > 0 || q.size() > 0) && cyc < 20000) begin
      if (!in_valid && xin.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
        in_x     = xin[0][DW-1:0];
        in_mode  = mdq[0];
        in_valid = 1'b1;
      end
      case (rdy_pat)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = ($urandom_range(1) == 1);
      endcase
      cycle();
      cyc++;
    end
    chk(cyc < 20000, "stream_timeout", cyc, 20000);
    chk(n_out == n0, "stream_count", n_out, n0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  typedef struct { longint x; bit mode; longint y; } vec_t;
  vec_t vt[$];

  initial begin
    int lat;
    vt.push_back('{0, 0, 32768});
    vt.push_back('{65536, 0, 47911});
    vt.push_back('{-65536, 0, 17625});
    vt.push_back('{2 * ONE, 0, 57724});
    vt.push_back('{-3 * ONE, 0, 3108});
    vt.push_back('{524288, 0, 65536});
    vt.push_back('{-524288, 0, 0});
    vt.push_back('{longint'(32'sh7FFFFFFF), 0, 65536});
    vt.push_back('{longint'(-32'sh80000000), 0, 0});
`ifdef SIGMOID_TANH_EN
    vt.push_back('{32768, 1, 30286});
    vt.push_back('{0, 1, 0});
    vt.push_back('{-32768, 1, -30286});
    vt.push_back('{4 * ONE, 1, 65536});
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(out_y == '0, "rst_out_y", sy(), 0);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single samples with latency check
    foreach (vt[i]) begin
      in_x = vt[i].x[DW-1:0]; in_mode = vt[i].mode; in_valid = 1'b1;
      #1 chk(in_ready == 1'b1, "single_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
      chk(lat == 3, $sformatf("vec[%0d]_latency", i), lat, 3);
      chk(sy() == vt[i].y, $sformatf("vec[%0d]_y", i), sy(), vt[i].y);
      @(negedge clk);
    end
    in_mode = 1'b0;

    // 16 back-to-back samples under a toggling out_ready
    for (int i = 0; i < 16; i++) begin
      xin.push_back(longint'($urandom_range(0, 20 * 65536)) - 10 * ONE);
      mdq.push_back(1'b0);
    end
    stream(1, 0);

    // sweep -9.0 .. +9.0 in 1/256 steps
    sweep_chk = 1; have_last = 0;
    for (int i = -2304; i <= 2304; i++) begin xin.push_back(longint'(i) * 256); mdq.push_back(1'b0); end
    stream(0, 0);
    sweep_chk = 0;

    // random stream, random backpressure and gaps
    for (int i = 0; i < 300; i++) begin
      if (i % 4 == 0) xin.push_back(longint'(int'($urandom)));
      else            xin.push_back(longint'($urandom_range(0, 20 * 65536)) - 10 * ONE);
`ifdef SIGMOID_TANH_EN
      mdq.push_back($urandom_range(1) == 1);
`else
      mdq.push_back(1'b0);
`endif
    end
    stream(2, 1);

    // reset with three samples in flight and a stalled output
    for (int i = 0; i < 3; i++) begin
      in_x = DW'((i + 1) * 65536); in_valid = 1'b1; in_mode = 1'b0;
      @(negedge clk);
    end
    chk(out_valid == 1'b1, "pre_rst_out_valid", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    #1 chk(in_ready == 1'b1, "in_rst_in_ready", in_ready, 1);
    @(negedge clk);
    chk(out_valid == 1'b0, "post_rst_out_valid", out_valid, 0);
    chk(out_y == '0, "post_rst_out_y", sy(), 0);
    chk(in_ready == 1'b1, "post_rst_in_ready", in_ready, 1);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk(out_valid == 1'b0, "no_stale_out", out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
